// File: rtl/flu_edit_cmd_sched.sv
// flu_edit_cmd_sched: attaches one queued edit command to each FLU packet at its SOP word
module flu_edit_cmd_sched #(
    parameter int DATA_WIDTH     = 256,
    parameter int SOP_POS_WIDTH  = 2,
    parameter int EOP_POS_WIDTH  = 5,
    parameter int OFFSET_WIDTH   = 10,
    parameter int CMD_FIFO_ITEMS = 8
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic [DATA_WIDTH-1:0]             RX_DATA,
    input  logic [SOP_POS_WIDTH-1:0]          RX_SOP_POS,
    input  logic [EOP_POS_WIDTH-1:0]          RX_EOP_POS,
    input  logic                              RX_SOP,
    input  logic                              RX_EOP,
    input  logic                              RX_SRC_RDY,
    output logic                              RX_DST_RDY,
    input  logic                              CMD_ENABLE,
    input  logic [OFFSET_WIDTH-1:0]           CMD_OFFSET,
    input  logic                              CMD_SRC_RDY,
    output logic                              CMD_DST_RDY,
    output logic [DATA_WIDTH-1:0]             TX_DATA,
    output logic [SOP_POS_WIDTH-1:0]          TX_SOP_POS,
    output logic [EOP_POS_WIDTH-1:0]          TX_EOP_POS,
    output logic                              TX_SOP,
    output logic                              TX_EOP,
    output logic                              TX_SRC_RDY,
    input  logic                              TX_DST_RDY,
    output logic                              TX_ENABLE,
    output logic [OFFSET_WIDTH-1:0]           TX_OFFSET,
    output logic [$clog2(CMD_FIFO_ITEMS):0]   CMD_COUNT,
    output logic [31:0]                       STALL_CNT
);
    localparam int AW = $clog2(CMD_FIFO_ITEMS);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(CMD_FIFO_ITEMS);

    logic [OFFSET_WIDTH:0] mem_q [CMD_FIFO_ITEMS];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [31:0] stall_q, stall_d;
    logic rdy_q, in_pkt_q, in_pkt_d;
    logic empty, gate, push, pop, xfer, stall, eop_after_sop;

    // A SOP word may only leave once a command is stored for it; other words are never held.
    assign empty = cnt_q == '0;
    assign gate = !RX_SOP || !empty;
    assign push = CMD_SRC_RDY && rdy_q;
    assign xfer = RX_SRC_RDY && TX_DST_RDY && gate;
    assign pop = xfer && RX_SOP;
    assign stall = RX_SRC_RDY && RX_SOP && empty && TX_DST_RDY;
    assign eop_after_sop = RX_EOP_POS >= {RX_SOP_POS, {(EOP_POS_WIDTH-SOP_POS_WIDTH){1'b0}}};

    assign TX_DATA = RX_DATA;
    assign TX_SOP_POS = RX_SOP_POS;
    assign TX_EOP_POS = RX_EOP_POS;
    assign TX_SOP = RX_SOP;
    assign TX_EOP = RX_EOP;
    assign TX_SRC_RDY = RX_SRC_RDY && gate;
    assign RX_DST_RDY = TX_DST_RDY && gate;
    assign TX_ENABLE = RX_SOP && !empty && mem_q[rd_q][OFFSET_WIDTH];
    assign TX_OFFSET = (RX_SOP && !empty) ? mem_q[rd_q][OFFSET_WIDTH-1:0] : '0;
    assign CMD_DST_RDY = rdy_q;
    assign CMD_COUNT = cnt_q;
    assign STALL_CNT = stall_q;

    // Next state of FIFO pointers, occupancy, stall counter and packet framing.
    always_comb begin
        wr_d = push ? wr_q + AW'(1) : wr_q;
        rd_d = pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        stall_d = (stall && stall_q != '1) ? stall_q + 32'd1 : stall_q;
        in_pkt_d = !xfer ? in_pkt_q : RX_SOP ? !(RX_EOP && eop_after_sop) : RX_EOP ? 1'b0 : in_pkt_q;
    end

    // Control state; the ready flag is registered from the post-update occupancy so a full FIFO refuses pushes.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            stall_q <= '0;
            rdy_q <= 1'b0;
            in_pkt_q <= 1'b0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
            stall_q <= stall_d;
            rdy_q <= cnt_d != FULL_CNT;
            in_pkt_q <= in_pkt_d;
        end
    end

    // Command storage; contents are only observed while the occupancy says they are valid.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_q] <= {CMD_ENABLE, CMD_OFFSET};
    end

    // A new packet may not start inside another one unless the same word closes the old one.
    sop_inside_pkt: assert property (@(posedge CLK) disable iff (RESET) (xfer && RX_SOP && in_pkt_q) |-> RX_EOP);
endmodule

// File: tb/tb_flu_edit_cmd_sched.sv
// tb_flu_edit_cmd_sched: scoreboard bench for the FLU edit command scheduler
module tb_flu_edit_cmd_sched;
    localparam int DW = 256, SW = 2, EW = 5, OW = 10, N = 8, CW = 4;

    logic CLK = 1'b0, RESET = 1'b1;
    logic [DW-1:0] RX_DATA = '0, TX_DATA;
    logic [SW-1:0] RX_SOP_POS = '0, TX_SOP_POS;
    logic [EW-1:0] RX_EOP_POS = '0, TX_EOP_POS;
    logic RX_SOP = 0, RX_EOP = 0, RX_SRC_RDY = 0, RX_DST_RDY;
    logic CMD_ENABLE = 0, CMD_SRC_RDY = 0, CMD_DST_RDY;
    logic [OW-1:0] CMD_OFFSET = '0, TX_OFFSET;
    logic TX_SOP, TX_EOP, TX_SRC_RDY, TX_DST_RDY = 1, TX_ENABLE;
    logic [CW-1:0] CMD_COUNT;
    logic [31:0] STALL_CNT;

    flu_edit_cmd_sched dut (
        .CLK(CLK), .RESET(RESET),
        .RX_DATA(RX_DATA), .RX_SOP_POS(RX_SOP_POS), .RX_EOP_POS(RX_EOP_POS),
        .RX_SOP(RX_SOP), .RX_EOP(RX_EOP), .RX_SRC_RDY(RX_SRC_RDY), .RX_DST_RDY(RX_DST_RDY),
        .CMD_ENABLE(CMD_ENABLE), .CMD_OFFSET(CMD_OFFSET), .CMD_SRC_RDY(CMD_SRC_RDY), .CMD_DST_RDY(CMD_DST_RDY),
        .TX_DATA(TX_DATA), .TX_SOP_POS(TX_SOP_POS), .TX_EOP_POS(TX_EOP_POS),
        .TX_SOP(TX_SOP), .TX_EOP(TX_EOP), .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY),
        .TX_ENABLE(TX_ENABLE), .TX_OFFSET(TX_OFFSET), .CMD_COUNT(CMD_COUNT), .STALL_CNT(STALL_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] data;
        logic sop, eop;
        logic [SW-1:0] sp;
        logic [EW-1:0] ep;
    } word_t;
    typedef struct {
        logic en;
        logic [OW-1:0] off;
    } cmd_t;

    word_t expq[$];
    cmd_t cmdq[$];
    int checks = 0, errors = 0, cmd_pushes = 0, cmd_target = 0;
    logic [31:0] stall_m = '0;
    bit rdy_ok = 0, bp_en = 0, cmd_auto = 0;
    logic mon_g, mon_stall;
    word_t mon_w;
    cmd_t mon_c;

    // Scoreboard monitor: checks gating/status every cycle, pops expectations on each transfer.
    always @(negedge CLK) begin
        if (RESET) rdy_ok = 0;
        else begin
            mon_g = !RX_SOP || cmdq.size() != 0;
            checks += 5;
            if (TX_SRC_RDY !== (RX_SRC_RDY && mon_g)) begin errors++; $display("FAIL tx_src_rdy: got %b expected %b", TX_SRC_RDY, RX_SRC_RDY && mon_g); end
            if (RX_DST_RDY !== (TX_DST_RDY && mon_g)) begin errors++; $display("FAIL rx_dst_rdy: got %b expected %b", RX_DST_RDY, TX_DST_RDY && mon_g); end
            if (CMD_COUNT !== CW'(cmdq.size())) begin errors++; $display("FAIL cmd_count: got %0d expected %0d", CMD_COUNT, cmdq.size()); end
            if (CMD_DST_RDY !== (rdy_ok && cmdq.size() < N)) begin errors++; $display("FAIL cmd_dst_rdy: got %b expected %b", CMD_DST_RDY, rdy_ok && cmdq.size() < N); end
            if (STALL_CNT !== stall_m) begin errors++; $display("FAIL stall_cnt: got %0d expected %0d", STALL_CNT, stall_m); end
            mon_stall = RX_SRC_RDY && RX_SOP && cmdq.size() == 0 && TX_DST_RDY;
            if (TX_SRC_RDY === 1'b1 && TX_DST_RDY === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin errors++; $display("FAIL unexpected_word: got data %h expected no transfer", TX_DATA); end
                else begin
                    mon_w = expq.pop_front();
                    if ({TX_DATA, TX_SOP, TX_EOP, TX_SOP_POS, TX_EOP_POS} !== {mon_w.data, mon_w.sop, mon_w.eop, mon_w.sp, mon_w.ep})
                        begin errors++; $display("FAIL word: got %h sop%b eop%b sp%0d ep%0d expected %h sop%b eop%b sp%0d ep%0d", TX_DATA, TX_SOP, TX_EOP, TX_SOP_POS, TX_EOP_POS, mon_w.data, mon_w.sop, mon_w.eop, mon_w.sp, mon_w.ep); end
                    checks++;
                    if (mon_w.sop) begin
                        if (cmdq.size() == 0) begin errors++; $display("FAIL sop_without_cmd: got transfer expected stall"); end
                        else begin
                            mon_c = cmdq.pop_front();
                            if ({TX_ENABLE, TX_OFFSET} !== {mon_c.en, mon_c.off}) begin errors++; $display("FAIL cmd: got en%b off%0d expected en%b off%0d", TX_ENABLE, TX_OFFSET, mon_c.en, mon_c.off); end
                        end
                    end else if ({TX_ENABLE, TX_OFFSET} !== '0) begin errors++; $display("FAIL cmd_non_sop: got en%b off%0d expected en0 off0", TX_ENABLE, TX_OFFSET); end
                end
            end
            if (CMD_SRC_RDY && CMD_DST_RDY) begin
                mon_c.en = CMD_ENABLE;
                mon_c.off = CMD_OFFSET;
                cmdq.push_back(mon_c);
                cmd_pushes++;
            end
            if (mon_stall && stall_m != '1) stall_m++;
            rdy_ok = 1;
        end
    end

    // Random output backpressure.
    initial forever begin
        @(posedge CLK); #1;
        if (bp_en) TX_DST_RDY = 1'($urandom_range(0, 1));
    end

    // Random command source, stopping after a fixed number of accepted commands.
    initial forever begin
        @(posedge CLK); #1;
        if (cmd_auto) begin
            if (cmd_pushes < cmd_target && $urandom_range(0, 1) == 1) begin
                CMD_SRC_RDY = 1;
                CMD_ENABLE = 1'($urandom_range(0, 1));
                CMD_OFFSET = OW'($urandom_range(0, 1023));
            end else CMD_SRC_RDY = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic present(input logic sop, input logic eop, input logic [SW-1:0] sp, input logic [EW-1:0] ep);
        word_t w;
        for (int i = 0; i < DW / 32; i++) w.data[i*32 +: 32] = $urandom();
        w.sop = sop; w.eop = eop; w.sp = sp; w.ep = ep;
        RX_DATA = w.data; RX_SOP = sop; RX_EOP = eop; RX_SOP_POS = sp; RX_EOP_POS = ep; RX_SRC_RDY = 1;
        expq.push_back(w);
    endtask

    task automatic wait_xfer();
        bit ok = 0;
        int n = 0;
        while (!ok && n < 100) begin
            @(negedge CLK); ok = RX_DST_RDY === 1'b1;
            @(posedge CLK); #1; n++;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL xfer_timeout: got no transfer expected transfer within 100 cycles"); end
    endtask

    task automatic send(input logic sop, input logic eop, input logic [SW-1:0] sp, input logic [EW-1:0] ep);
        present(sop, eop, sp, ep);
        wait_xfer();
    endtask

    task automatic push_cmd(input logic en, input logic [OW-1:0] off);
        CMD_ENABLE = en; CMD_OFFSET = off; CMD_SRC_RDY = 1;
        @(posedge CLK); #1;
        CMD_SRC_RDY = 0;
    endtask

    task automatic idle();
        RX_SRC_RDY = 0; RX_SOP = 0; RX_EOP = 0;
    endtask

    task automatic test_reset();
        RESET = 1; RX_SOP = 1; RX_SRC_RDY = 1;
        repeat (2) @(posedge CLK); #3;
        checks += 7;
        if (CMD_COUNT !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", CMD_COUNT); end
        if (STALL_CNT !== 32'd0) begin errors++; $display("FAIL rst_stall: got %0d expected 0", STALL_CNT); end
        if (CMD_DST_RDY !== 1'b0) begin errors++; $display("FAIL rst_cmd_rdy: got %b expected 0", CMD_DST_RDY); end
        if (TX_ENABLE !== 1'b0) begin errors++; $display("FAIL rst_enable: got %b expected 0", TX_ENABLE); end
        if (TX_OFFSET !== 10'd0) begin errors++; $display("FAIL rst_offset: got %0d expected 0", TX_OFFSET); end
        if (TX_SRC_RDY !== 1'b0) begin errors++; $display("FAIL rst_tx_src_rdy: got %b expected 0", TX_SRC_RDY); end
        if (RX_DST_RDY !== 1'b0) begin errors++; $display("FAIL rst_rx_dst_rdy: got %b expected 0", RX_DST_RDY); end
        idle();
        @(posedge CLK); #1; RESET = 0;
        @(posedge CLK); #2;
        checks++;
        if (CMD_DST_RDY !== 1'b1) begin errors++; $display("FAIL rel_cmd_rdy: got %b expected 1", CMD_DST_RDY); end
    endtask

    task automatic test_stall_then_cmd();
        logic [31:0] s0 = stall_m;
        present(1, 0, 0, 0);
        repeat (4) @(posedge CLK); #2;
        checks += 2;
        if (STALL_CNT !== s0 + 4) begin errors++; $display("FAIL stall_count4: got %0d expected %0d", STALL_CNT, s0 + 4); end
        if (TX_SRC_RDY !== 1'b0) begin errors++; $display("FAIL stall_held: got %b expected 0", TX_SRC_RDY); end
        push_cmd(1, 14); #2;
        checks += 4;
        if (TX_SRC_RDY !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", TX_SRC_RDY); end
        if (TX_ENABLE !== 1'b1) begin errors++; $display("FAIL stall_enable: got %b expected 1", TX_ENABLE); end
        if (TX_OFFSET !== 10'd14) begin errors++; $display("FAIL stall_offset: got %0d expected 14", TX_OFFSET); end
        if (CMD_COUNT !== 4'd1) begin errors++; $display("FAIL stall_count_cmd: got %0d expected 1", CMD_COUNT); end
        wait_xfer();
        send(0, 0, 0, 0);
        send(0, 1, 0, 31);
        idle(); #2;
        checks += 2;
        if (CMD_COUNT !== 4'd0) begin errors++; $display("FAIL stall_drain: got %0d expected 0", CMD_COUNT); end
        if (STALL_CNT !== s0 + 5) begin errors++; $display("FAIL stall_final: got %0d expected %0d", STALL_CNT, s0 + 5); end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < N; i++) begin
            CMD_ENABLE = 1; CMD_OFFSET = OW'(i); CMD_SRC_RDY = 1;
            @(posedge CLK); #1;
        end
        CMD_OFFSET = 10'd99; #2;
        checks += 2;
        if (CMD_COUNT !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", CMD_COUNT); end
        if (CMD_DST_RDY !== 1'b0) begin errors++; $display("FAIL full_rdy: got %b expected 0", CMD_DST_RDY); end
        @(posedge CLK); #2;
        CMD_SRC_RDY = 0;
        checks++;
        if (CMD_COUNT !== 4'd8) begin errors++; $display("FAIL full_refused: got %0d expected 8", CMD_COUNT); end
        for (int i = 0; i < N; i++) begin
            present(1, 1, 0, 31); #1;
            checks++;
            if (TX_OFFSET !== OW'(i)) begin errors++; $display("FAIL full_order: got %0d expected %0d", TX_OFFSET, i); end
            wait_xfer();
        end
        idle(); #2;
        checks += 2;
        if (CMD_COUNT !== 4'd0) begin errors++; $display("FAIL full_drain: got %0d expected 0", CMD_COUNT); end
        if (CMD_DST_RDY !== 1'b1) begin errors++; $display("FAIL full_rdy_back: got %b expected 1", CMD_DST_RDY); end
    endtask

    task automatic test_eop_sop_word();
        push_cmd(1, 3);
        send(1, 0, 0, 0);
        present(1, 1, 2, 7);
        repeat (3) @(posedge CLK); #2;
        checks += 2;
        if (TX_SRC_RDY !== 1'b0) begin errors++; $display("FAIL es_held: got %b expected 0", TX_SRC_RDY); end
        if (RX_DST_RDY !== 1'b0) begin errors++; $display("FAIL es_rx_held: got %b expected 0", RX_DST_RDY); end
        push_cmd(0, 5); #2;
        checks += 4;
        if (TX_SRC_RDY !== 1'b1) begin errors++; $display("FAIL es_release: got %b expected 1", TX_SRC_RDY); end
        if (TX_ENABLE !== 1'b0) begin errors++; $display("FAIL es_enable: got %b expected 0", TX_ENABLE); end
        if (TX_OFFSET !== 10'd5) begin errors++; $display("FAIL es_offset: got %0d expected 5", TX_OFFSET); end
        if (TX_EOP !== 1'b1) begin errors++; $display("FAIL es_eop: got %b expected 1", TX_EOP); end
        wait_xfer();
        send(0, 1, 0, 31);
        idle();
    endtask

    task automatic test_push_pop_same();
        push_cmd(1, 20);
        present(1, 1, 0, 31);
        CMD_ENABLE = 1; CMD_OFFSET = 10'd21; CMD_SRC_RDY = 1; #2;
        checks += 2;
        if (TX_OFFSET !== 10'd20) begin errors++; $display("FAIL pp_old_head: got %0d expected 20", TX_OFFSET); end
        if (CMD_COUNT !== 4'd1) begin errors++; $display("FAIL pp_count_before: got %0d expected 1", CMD_COUNT); end
        wait_xfer();
        CMD_SRC_RDY = 0;
        present(1, 1, 0, 31); #1;
        checks += 2;
        if (CMD_COUNT !== 4'd1) begin errors++; $display("FAIL pp_count_after: got %0d expected 1", CMD_COUNT); end
        if (TX_OFFSET !== 10'd21) begin errors++; $display("FAIL pp_new_head: got %0d expected 21", TX_OFFSET); end
        wait_xfer();
        idle();
    endtask

    task automatic test_random();
        int len, spi;
        bp_en = 1; cmd_target = cmd_pushes + 200; cmd_auto = 1;
        for (int p = 0; p < 200; p++) begin
            len = $urandom_range(1, 4);
            spi = $urandom_range(0, 3);
            if (len == 1) send(1, 1, SW'(spi), EW'($urandom_range(spi * 8, 31)));
            else begin
                send(1, 0, SW'(spi), 0);
                for (int k = 1; k < len - 1; k++) send(0, 0, 0, 0);
                send(0, 1, 0, EW'($urandom_range(0, 31)));
            end
            if ($urandom_range(0, 3) == 0) begin idle(); @(posedge CLK); #1; end
        end
        idle(); bp_en = 0; cmd_auto = 0;
        @(posedge CLK); #1;
        TX_DST_RDY = 1; CMD_SRC_RDY = 0; #2;
        checks += 3;
        if (expq.size() != 0) begin errors++; $display("FAIL rnd_words_left: got %0d expected 0", expq.size()); end
        if (cmd_pushes != cmd_target) begin errors++; $display("FAIL rnd_cmds_pushed: got %0d expected %0d", cmd_pushes, cmd_target); end
        if (CMD_COUNT !== 4'd0) begin errors++; $display("FAIL rnd_count: got %0d expected 0", CMD_COUNT); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) push_cmd(1, OW'(30 + i));
        send(1, 0, 1, 0);
        present(0, 0, 0, 0); #2;
        RESET = 1;
        expq.delete(); cmdq.delete(); stall_m = '0;
        idle(); #1;
        checks += 3;
        if (CMD_COUNT !== 4'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", CMD_COUNT); end
        if (STALL_CNT !== 32'd0) begin errors++; $display("FAIL mid_stall: got %0d expected 0", STALL_CNT); end
        if (CMD_DST_RDY !== 1'b0) begin errors++; $display("FAIL mid_rdy_rst: got %b expected 0", CMD_DST_RDY); end
        @(posedge CLK); #1; RESET = 0;
        @(posedge CLK); #2;
        checks += 2;
        if (CMD_DST_RDY !== 1'b1) begin errors++; $display("FAIL mid_rdy_rel: got %b expected 1", CMD_DST_RDY); end
        if (CMD_COUNT !== 4'd0) begin errors++; $display("FAIL mid_count_rel: got %0d expected 0", CMD_COUNT); end
        present(1, 0, 0, 0);
        repeat (2) @(posedge CLK); #2;
        checks += 2;
        if (TX_SRC_RDY !== 1'b0) begin errors++; $display("FAIL mid_sop_wait: got %b expected 0", TX_SRC_RDY); end
        if (STALL_CNT !== 32'd2) begin errors++; $display("FAIL mid_stall2: got %0d expected 2", STALL_CNT); end
        push_cmd(1, 40); #2;
        checks++;
        if (TX_OFFSET !== 10'd40) begin errors++; $display("FAIL mid_offset: got %0d expected 40", TX_OFFSET); end
        wait_xfer();
        send(0, 1, 0, 31);
        idle();
    endtask

    initial begin
        test_reset();
        test_stall_then_cmd();
        test_fifo_full();
        test_eop_sop_word();
        test_push_pop_same();
        test_random();
        test_reset_mid();
        repeat (3) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
